e_unary_dec: RTL and testbench
==============================

# e_unary_dec

Registered, flow-controlled decoder that sits directly downstream of the unary admission stage. It accepts a W-bit unary/thermometer vector per transfer and re-checks admission with the same rule. For each vector it emits the binary run length, the compliment flag, and an error flag. It is a two-stage valid/ready pipeline with full throughput and backpressure, intended to feed binary consumers of thermometer codes.

## Interface
- W, 16, vector width; W >= 2.
- P_ADMIT_COMPLIMENT_EN, 1, admit the complimented (MSB-set) unary form.
- LW, $clog2(W) (derived, localparam), width of o_out_len.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_in_vld  in  1  input vector valid.
- i_in_x  in  W  input vector.
- o_in_rdy  out  1  block can accept input this cycle.
- o_out_vld  out  1  output result valid.
- i_out_rdy  in  1  downstream accepts result this cycle.
- o_out_len  out  LW  decoded run length.
- o_out_is_compliment  out  1  vector was complimented form.
- o_out_err  out  1  vector rejected (not a legal unary code).
- o_err_cnt  out  16  rejected-vector count (see Configuration).

## Operation
- Transfer in: i_in_vld && o_in_rdy. Transfer out: o_out_vld && i_out_rdy.
- Stage 0 (S0) registers i_in_x and valid. Stage 1 (S1) registers the decode result and valid. Outputs are driven directly from S1 flops.
- Admission rule (computed on S0 contents):
  - e[i] = x[i]^x[i-1] for i in 1..W-1.
  - Legal when exactly one e bit is set, or x == 0.
  - Also legal when x == all-ones, only if P_ADMIT_COMPLIMENT_EN=1.
  - With P_ADMIT_COMPLIMENT_EN=0, any x with x[W-1]=1 is illegal.
- Decode of a legal vector:
  - x[W-1]=0: len = popcount(x); compliment=0. Range 0..W-1.
  - x[W-1]=1 (compliment enabled): len = W - popcount(x), i.e. the count of LSB zeros; compliment=1. An all-ones x gives len=0.
- Decode of an illegal vector: err=1, len=0, compliment=0.
- Advance conditions:
  - s1_adv = !s1_vld || i_out_rdy.
  - s0_adv = !s0_vld || s1_adv.
  - o_in_rdy = s0_adv. This is a combinational path from i_out_rdy and is permitted.
- While o_out_vld && !i_out_rdy, all output payload bits hold stable.
- No FSM. Pipeline occupancy is 0..2, held in the two valid bits.

## Timing
- Reset values:
  - o_out_vld=0, o_out_len=0, o_out_is_compliment=0, o_out_err=0, o_err_cnt=0.
  - o_in_rdy=1 in the first cycle after reset.
- Latency: a vector accepted at edge N appears on o_out_vld after edge N+1, i.e. 2 cycles, when unstalled.
- Throughput: 1 vector/cycle sustained while i_out_rdy=1.
- Simultaneous transfer in and out with both stages full: legal. Occupancy stays 2 and o_in_rdy stays 1.
- When S1 is full and i_out_rdy=0, S0 fills and o_in_rdy drops the same cycle. No input is lost or duplicated.
- Reset asserted mid-operation: both valid bits clear at that edge, in-flight vectors are discarded, and the counter is cleared. rst has priority over every other update.

## Configuration
- Macro: E_UNARY_DEC_ERR_CNT_EN.
- Defined:
  - o_err_cnt is a 16-bit counter that increments on each output transfer with o_out_err=1.
  - It saturates at 16'hFFFF and does not wrap.
- Undefined: the counter is not built and o_err_cnt is tied to 0. The port exists in both builds.

## Test plan
- W=16, compliment enabled, i_out_rdy=1, inputs 0x0007, 0xFFF8, 0x0000, 0xFFFF on consecutive cycles. Required responses, 2 cycles later on consecutive cycles:
  - len=3, compliment=0, err=0.
  - len=3, compliment=1, err=0.
  - len=0, compliment=0, err=0.
  - len=0, compliment=1, err=0.
- Illegal inputs 0x0005 and 0x00F0 -> err=1, len=0, compliment=0 for each. With the macro defined, o_err_cnt=2.
- P_ADMIT_COMPLIMENT_EN=0 with inputs 0xFFF8 and 0xFFFF -> both err=1. 0x7FFF -> len=15, err=0.
- Backpressure:
  - Stream 0x0001..0x7FFF (15 vectors) with i_out_rdy=0 for cycles 3-7.
  - o_in_rdy drops once two are held.
  - Output sequence is len 1..15 with no gaps, duplicates or payload change while stalled.
- Assert rst for one cycle while both stages are valid -> next cycle o_out_vld=0, o_in_rdy=1, o_err_cnt=0; the next input appears 2 cycles after acceptance.
- Macro defined, counter forced near limit: drive 0xFFFF+2 illegal transfers -> o_err_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/e_unary_dec.sv
// Two-stage valid/ready decoder for unary/thermometer vectors: re-checks admission, emits run length.
// Optional rejected-vector counter enabled by E_UNARY_DEC_ERR_CNT_EN.
module e_unary_dec #(
  parameter int W                     = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
  localparam int LW                   = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_in_vld,
  input  logic [W-1:0]  i_in_x,
  output logic          o_in_rdy,
  output logic          o_out_vld,
  input  logic          i_out_rdy,
  output logic [LW-1:0] o_out_len,
  output logic          o_out_is_compliment,
  output logic          o_out_err,
  output logic [15:0]   o_err_cnt
);

  localparam logic [W-2:0] E_ONE = 1;

  // [0] = S0 holds the raw vector, [1] = S1 holds the decoded result
  logic [1:0]    r_vld_pipe;
  logic [W-1:0]  r_s0_x;
  logic [LW-1:0] r_len;
  logic          r_comp;
  logic          r_err;

  logic          w_s1_adv;
  logic          w_s0_adv;
  logic [W-2:0]  w_e;
  logic          w_one_e;
  logic          w_zero;
  logic          w_ones;
  logic [LW:0]   w_pop;
  logic [LW:0]   w_cpl;
  logic [LW-1:0] w_len;
  logic          w_comp;
  logic          w_err;

  assign w_s1_adv = !r_vld_pipe[1] || i_out_rdy;
  assign w_s0_adv = !r_vld_pipe[0] || w_s1_adv;
  assign o_in_rdy = w_s0_adv;

  // A legal code has a single 0/1 boundary between adjacent bits
  assign w_e     = r_s0_x[W-1:1] ^ r_s0_x[W-2:0];
  assign w_one_e = (w_e != '0) && ((w_e & (w_e - E_ONE)) == '0);
  assign w_zero  = (r_s0_x == '0);
  assign w_ones  = &r_s0_x;
  assign w_cpl   = (LW+1)'(W) - w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++)
      w_pop = w_pop + {{LW{1'b0}}, r_s0_x[i]};
  end

  always_comb begin
    w_err  = 1'b1;
    w_comp = 1'b0;
    w_len  = '0;
    if (!r_s0_x[W-1] && (w_zero || w_one_e)) begin
      w_err = 1'b0;
      w_len = w_pop[LW-1:0];
    end else if (P_ADMIT_COMPLIMENT_EN && r_s0_x[W-1] && (w_ones || w_one_e)) begin
      w_err  = 1'b0;
      w_comp = 1'b1;
      w_len  = w_cpl[LW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s0_x     <= '0;
      r_len      <= '0;
      r_comp     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_s0_adv) begin
        r_vld_pipe[0] <= i_in_vld;
        if (i_in_vld) r_s0_x <= i_in_x;
      end
      // payload only moves when S1 advances, so it holds under backpressure
      if (w_s1_adv) begin
        r_vld_pipe[1] <= r_vld_pipe[0];
        if (r_vld_pipe[0]) begin
          r_len  <= w_len;
          r_comp <= w_comp;
          r_err  <= w_err;
        end
      end
    end
  end

  assign o_out_vld           = r_vld_pipe[1];
  assign o_out_len           = r_len;
  assign o_out_is_compliment = r_comp;
  assign o_out_err           = r_err;

`ifdef E_UNARY_DEC_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_err_cnt <= '0;
    else if (r_vld_pipe[1] && i_out_rdy && r_err && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_e_unary_dec.sv
// Bench for e_unary_dec: compliment-enabled and compliment-disabled instances share stimulus,
// checked against a pattern-matching reference model.
module tb_e_unary_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_in_vld;
  logic [15:0] i_in_x;
  logic        i_out_rdy;

  logic        in_rdy_a, vld_a, comp_a, err_a;
  logic [3:0]  len_a;
  logic [15:0] cnt_a;
  logic        in_rdy_b, vld_b, comp_b, err_b;
  logic [3:0]  len_b;
  logic [15:0] cnt_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mcnt_a = 0;
  int mcnt_b = 0;

  typedef struct { logic [15:0] x; int cyc; } in_t;
  typedef struct { logic [5:0] a; logic [5:0] b; int cyc; } out_t;
  in_t  inq[$];
  out_t outq[$];

  always #5 clk = ~clk;

  e_unary_dec #(.W(16), .P_ADMIT_COMPLIMENT_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .i_in_vld(i_in_vld), .i_in_x(i_in_x), .o_in_rdy(in_rdy_a),
    .o_out_vld(vld_a), .i_out_rdy(i_out_rdy), .o_out_len(len_a),
    .o_out_is_compliment(comp_a), .o_out_err(err_a), .o_err_cnt(cnt_a));

  e_unary_dec #(.W(16), .P_ADMIT_COMPLIMENT_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .i_in_vld(i_in_vld), .i_in_x(i_in_x), .o_in_rdy(in_rdy_b),
    .o_out_vld(vld_b), .i_out_rdy(i_out_rdy), .o_out_len(len_b),
    .o_out_is_compliment(comp_b), .o_out_err(err_b), .o_err_cnt(cnt_b));

  // transfer recorder; flow control is data independent so both instances move together
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && i_in_vld && in_rdy_a) inq.push_back('{i_in_x, cyc});
    if (!rst && vld_a && i_out_rdy)
      outq.push_back('{{err_a, comp_a, len_a}, {err_b, comp_b, len_b}, cyc});
  end

  // {err, compliment, len}: legal forms are 2^k-1 and, if enabled, its bitwise inverse
  function automatic logic [5:0] model(input logic [15:0] x, input bit comp_en);
    logic [31:0] t;
    for (int k = 0; k < 16; k++) begin
      t = (32'd1 << k) - 32'd1;
      if (x == t[15:0]) return {2'b00, 4'(k)};
    end
    if (comp_en)
      for (int k = 0; k < 16; k++) begin
        t = (32'd1 << k) - 32'd1;
        if (x == ~t[15:0]) return {2'b01, 4'(k)};
      end
    return 6'h20;
  endfunction

  function automatic int cnt_exp(input int m);
`ifdef E_UNARY_DEC_ERR_CNT_EN
    return m;
`else
    return 0;
`endif
  endfunction

  function automatic int sat_inc(input int m);
    return (m < 65535) ? m + 1 : m;
  endfunction

  function automatic logic [15:0] gen_x();
    int k;
    logic [31:0] t;
    k = $urandom_range(0, 15);
    t = (32'd1 << k) - 32'd1;
    case ($urandom_range(0, 2))
      0:       return t[15:0];
      1:       return ~t[15:0];
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic cycle(input logic v, input logic [15:0] x, input logic ordy, output bit acc);
    @(negedge clk);
    i_in_vld = v; i_in_x = x; i_out_rdy = ordy;
    #1;
    acc = v && in_rdy_a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_in_vld = 1'b0; i_in_x = '0; i_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", vld_a); end
    total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL reset_vld_b: got %b want 0", vld_b); end
    total++; if ({err_a, comp_a, len_a} !== 6'h00) begin bad++; $display("FAIL reset_payload: got %h want 00", {err_a, comp_a, len_a}); end
    total++; if (cnt_a !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", cnt_a); end
    total++; if (in_rdy_a !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", in_rdy_a); end
    mcnt_a = 0; mcnt_b = 0;
    inq.delete(); outq.delete();
  endtask

  task automatic test_known();
    logic [15:0] xs [7] = '{16'h0007, 16'hFFF8, 16'h0000, 16'hFFFF, 16'h0005, 16'h00F0, 16'h7FFF};
    logic [5:0]  ea [7] = '{6'h03, 6'h13, 6'h00, 6'h10, 6'h20, 6'h20, 6'h0F};
    logic [5:0]  eb [7] = '{6'h03, 6'h20, 6'h00, 6'h20, 6'h20, 6'h20, 6'h0F};
    bit acc;
    inq.delete(); outq.delete();
    for (int i = 0; i < 7; i++) cycle(1'b1, xs[i], 1'b1, acc);
    for (int t = 0; t < 10 && outq.size() < 7; t++) cycle(1'b0, '0, 1'b1, acc);
    total++; if (outq.size() != 7) begin bad++; $display("FAIL known_count: got %0d want 7", outq.size()); end
    for (int i = 0; i < 7 && i < outq.size() && i < inq.size(); i++) begin
      total++; if (outq[i].a !== ea[i]) begin bad++; $display("FAIL known_a[%0d]: got %h want %h", i, outq[i].a, ea[i]); end
      total++; if (outq[i].b !== eb[i]) begin bad++; $display("FAIL known_b[%0d]: got %h want %h", i, outq[i].b, eb[i]); end
      total++; if (outq[i].cyc - inq[i].cyc != 2) begin bad++; $display("FAIL known_latency[%0d]: got %0d want 2", i, outq[i].cyc - inq[i].cyc); end
      total++; if (outq[i].cyc != outq[0].cyc + i) begin bad++; $display("FAIL known_gap[%0d]: got %0d want %0d", i, outq[i].cyc, outq[0].cyc + i); end
      if (ea[i][5]) mcnt_a = sat_inc(mcnt_a);
      if (eb[i][5]) mcnt_b = sat_inc(mcnt_b);
    end
    total++; if (cnt_a !== 16'(cnt_exp(mcnt_a))) begin bad++; $display("FAIL known_cnt_a: got %0d want %0d", cnt_a, cnt_exp(mcnt_a)); end
    total++; if (cnt_b !== 16'(cnt_exp(mcnt_b))) begin bad++; $display("FAIL known_cnt_b: got %0d want %0d", cnt_b, cnt_exp(mcnt_b)); end
  endtask

  task automatic test_random();
    bit acc;
    logic [5:0] ma, mb;
    inq.delete(); outq.delete();
    for (int c = 0; c < 1500; c++) begin
      cycle($urandom_range(0, 3) != 0, gen_x(), $urandom_range(0, 3) != 0, acc);
      total++; if (in_rdy_b !== in_rdy_a) begin bad++; $display("FAIL random_rdy_match: got %b want %b", in_rdy_b, in_rdy_a); end
    end
    for (int t = 0; t < 20 && outq.size() < inq.size(); t++) cycle(1'b0, '0, 1'b1, acc);
    total++; if (outq.size() != inq.size()) begin bad++; $display("FAIL random_count: got %0d want %0d", outq.size(), inq.size()); end
    for (int i = 0; i < outq.size() && i < inq.size(); i++) begin
      ma = model(inq[i].x, 1'b1);
      mb = model(inq[i].x, 1'b0);
      total++; if (outq[i].a !== ma) begin bad++; $display("FAIL random_a x=%h: got %h want %h", inq[i].x, outq[i].a, ma); end
      total++; if (outq[i].b !== mb) begin bad++; $display("FAIL random_b x=%h: got %h want %h", inq[i].x, outq[i].b, mb); end
      if (ma[5]) mcnt_a = sat_inc(mcnt_a);
      if (mb[5]) mcnt_b = sat_inc(mcnt_b);
    end
    total++; if (cnt_a !== 16'(cnt_exp(mcnt_a))) begin bad++; $display("FAIL random_cnt_a: got %0d want %0d", cnt_a, cnt_exp(mcnt_a)); end
    total++; if (cnt_b !== 16'(cnt_exp(mcnt_b))) begin bad++; $display("FAIL random_cnt_b: got %0d want %0d", cnt_b, cnt_exp(mcnt_b)); end
  endtask

  task automatic test_backpressure();
    int idx = 1;
    bit acc, held_vld = 0, saw_drop = 0;
    logic [5:0] held;
    logic [31:0] t;
    bit acc2;
    inq.delete(); outq.delete();
    for (int c = 1; c < 60 && idx <= 15; c++) begin
      @(negedge clk);
      if (held_vld) begin
        total++; if ({err_a, comp_a, len_a} !== held || vld_a !== 1'b1) begin
          bad++; $display("FAIL stall_hold: got %h want %h", {err_a, comp_a, len_a}, held); end
      end
      t = (32'd1 << idx) - 32'd1;
      i_in_vld = 1'b1; i_in_x = t[15:0]; i_out_rdy = !(c >= 3 && c <= 7);
      #1;
      if (!in_rdy_a) saw_drop = 1;
      acc = in_rdy_a;
      held_vld = vld_a && !i_out_rdy;
      held = {err_a, comp_a, len_a};
      @(posedge clk);
      if (acc) idx++;
    end
    #1;
    total++; if (saw_drop !== 1'b1) begin bad++; $display("FAIL bp_rdy_drop: got %b want 1", saw_drop); end
    for (int t2 = 0; t2 < 10 && outq.size() < 15; t2++) cycle(1'b0, '0, 1'b1, acc2);
    total++; if (outq.size() != 15) begin bad++; $display("FAIL bp_count: got %0d want 15", outq.size()); end
    for (int i = 0; i < outq.size() && i < 15; i++) begin
      total++; if (outq[i].a !== {2'b00, 4'(i + 1)}) begin bad++; $display("FAIL bp_seq_a[%0d]: got %h want %h", i, outq[i].a, {2'b00, 4'(i + 1)}); end
      total++; if (outq[i].b !== {2'b00, 4'(i + 1)}) begin bad++; $display("FAIL bp_seq_b[%0d]: got %h want %h", i, outq[i].b, {2'b00, 4'(i + 1)}); end
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    cycle(1'b1, 16'h0005, 1'b0, acc);
    cycle(1'b1, 16'h0003, 1'b0, acc);
    @(negedge clk);
    total++; if (vld_a !== 1'b1 || in_rdy_a !== 1'b0) begin bad++; $display("FAIL mid_full: got vld=%b rdy=%b want 1 0", vld_a, in_rdy_a); end
    rst = 1'b1; i_in_vld = 1'b0; i_out_rdy = 1'b1;
    @(negedge clk);
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL mid_vld: got %b want 0", vld_a); end
    total++; if (in_rdy_a !== 1'b1) begin bad++; $display("FAIL mid_rdy: got %b want 1", in_rdy_a); end
    total++; if (cnt_a !== 16'h0 || cnt_b !== 16'h0) begin bad++; $display("FAIL mid_cnt: got %h/%h want 0", cnt_a, cnt_b); end
    rst = 1'b0;
    mcnt_a = 0; mcnt_b = 0;
    inq.delete(); outq.delete();
    cycle(1'b1, 16'h00FF, 1'b1, acc);
    @(negedge clk);
    i_in_vld = 1'b0;
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL mid_lat_early: got %b want 0", vld_a); end
    @(negedge clk);
    total++; if (vld_a !== 1'b1 || {err_a, comp_a, len_a} !== 6'h08) begin
      bad++; $display("FAIL mid_lat_out: got vld=%b %h want 1 08", vld_a, {err_a, comp_a, len_a}); end
    cycle(1'b0, '0, 1'b1, acc);
    total++; if (outq.size() != 1 || inq.size() != 1) begin bad++; $display("FAIL mid_count: got %0d want 1", outq.size()); end
  endtask

`ifdef E_UNARY_DEC_ERR_CNT_EN
  task automatic test_saturate();
    bit acc;
    int n = 65537;
    inq.delete(); outq.delete();
    for (int i = 0; i < n; i++) cycle(1'b1, 16'h0005, 1'b1, acc);
    for (int t = 0; t < 10 && outq.size() < n; t++) cycle(1'b0, '0, 1'b1, acc);
    total++; if (outq.size() != n) begin bad++; $display("FAIL sat_count: got %0d want %0d", outq.size(), n); end
    for (int i = 0; i < outq.size(); i++) begin mcnt_a = sat_inc(mcnt_a); mcnt_b = sat_inc(mcnt_b); end
    total++; if (cnt_a !== 16'(mcnt_a)) begin bad++; $display("FAIL sat_cnt_a: got %h want %h", cnt_a, 16'(mcnt_a)); end
    total++; if (cnt_b !== 16'(mcnt_b)) begin bad++; $display("FAIL sat_cnt_b: got %h want %h", cnt_b, 16'(mcnt_b)); end
    inq.delete(); outq.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_known();
    test_random();
    test_backpressure();
    test_reset_mid();
`ifdef E_UNARY_DEC_ERR_CNT_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
